// File: rtl/ace_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ace_responder_if
// Brief    : Request/response bundle between a cache controller and the
//            ace_responder interconnect stub.
// Revision : 1.0  initial release
// ============================================================================
interface ace_responder_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic              read_req;
   logic              write_req;
   logic              invalid_req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              peer_shared;
   logic              ace_ready;
   logic [DATA_W-1:0] rdata;
   logic [2:0]        resp_state;
   logic              peer_inval;
   logic              busy;

   // Cache controller side
   modport master (
      output read_req, write_req, invalid_req, addr, wdata, peer_shared,
      input  ace_ready, rdata, resp_state, peer_inval, busy
   );

   // Interconnect side
   modport slave (
      input  read_req, write_req, invalid_req, addr, wdata, peer_shared,
      output ace_ready, rdata, resp_state, peer_inval, busy
   );
endinterface
`default_nettype wire

// File: rtl/ace_responder.sv
`default_nettype none
// ============================================================================
// Module   : ace_responder
// Brief    : Serialising ACE interconnect stub with backing memory and
//            per-operation latency counter; one response pulse per request.
// Revision : 1.0  initial release
// ============================================================================
module ace_responder #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 2,
   parameter int INV_LAT   = 3
) (
   input  wire logic     clk,
   input  wire logic     reset,
   ace_responder_if.slave bus
);

   localparam int c_DEPTH   = 2 ** ADDR_W;
   localparam int c_MAX_LAT = (READ_LAT > WRITE_LAT)
                              ? ((READ_LAT > INV_LAT) ? READ_LAT : INV_LAT)
                              : ((WRITE_LAT > INV_LAT) ? WRITE_LAT : INV_LAT);
   localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

   localparam logic [2:0] c_ST_UC = 3'b000;
   localparam logic [2:0] c_ST_SC = 3'b010;
   localparam logic [2:0] c_ST_I  = 3'b100;

   localparam logic [1:0] c_OP_RD  = 2'd0;
   localparam logic [1:0] c_OP_WR  = 2'd1;
   localparam logic [1:0] c_OP_INV = 2'd2;

   localparam logic [c_CNT_W-1:0] c_CNT_RD  = c_CNT_W'(READ_LAT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_WR  = c_CNT_W'(WRITE_LAT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_INV = c_CNT_W'(INV_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_peer_shared;
   logic                r_ace_ready;
   logic                r_peer_inval;
   logic                r_busy;
   logic [DATA_W-1:0]   r_rdata;
   logic [2:0]          r_resp_state;
   logic [DATA_W-1:0]   r_mem [c_DEPTH];

   logic                w_any_req;
   logic [1:0]          w_sel_op;
   logic [c_CNT_W-1:0]  w_sel_cnt;
   logic                w_resp_edge;
   logic                w_mem_we;

   // Fixed priority: write-back > invalidate > read
   always_comb begin
      w_sel_op  = c_OP_RD;
      w_sel_cnt = c_CNT_RD;
      if (bus.write_req) begin
         w_sel_op  = c_OP_WR;
         w_sel_cnt = c_CNT_WR;
      end else if (bus.invalid_req) begin
         w_sel_op  = c_OP_INV;
         w_sel_cnt = c_CNT_INV;
      end
   end

   assign w_any_req   = bus.read_req | bus.write_req | bus.invalid_req;
   assign w_resp_edge = (r_state == S_WAIT) && (r_cnt == '0);
   // A reset on the commit edge must drop the pending write-back
   assign w_mem_we    = !reset && w_resp_edge && (r_op == c_OP_WR);

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_op          <= c_OP_RD;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_peer_shared <= 1'b0;
         r_ace_ready   <= 1'b0;
         r_peer_inval  <= 1'b0;
         r_busy        <= 1'b0;
         r_rdata       <= '0;
         r_resp_state  <= c_ST_I;
      end else begin
         r_ace_ready  <= 1'b0;
         r_peer_inval <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_op          <= w_sel_op;
                  r_addr        <= bus.addr;
                  r_wdata       <= bus.wdata;
                  r_peer_shared <= bus.peer_shared;
                  r_cnt         <= w_sel_cnt;
                  r_peer_inval  <= (w_sel_op == c_OP_INV);
                  r_busy        <= 1'b1;
                  r_state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state     <= S_RESP;
                  r_ace_ready <= 1'b1;
                  case (r_op)
                     c_OP_WR:  r_resp_state <= c_ST_I;
                     c_OP_INV: r_resp_state <= c_ST_UC;
                     default: begin
                        r_rdata      <= r_mem[r_addr];
                        r_resp_state <= r_peer_shared ? c_ST_SC : c_ST_UC;
                     end
                  endcase
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ace_ready  = r_ace_ready;
   assign bus.peer_inval = r_peer_inval;
   assign bus.busy       = r_busy;
   assign bus.rdata      = r_rdata;
   assign bus.resp_state = r_resp_state;

endmodule
`default_nettype wire

// File: tb/tb_ace_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ace_responder
// Brief    : Directed self-checking bench for ace_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_ace_responder;

   localparam int c_RD_LAT  = 4;
   localparam int c_WR_LAT  = 2;
   localparam int c_INV_LAT = 3;
   localparam int c_BOUND   = 20;

   localparam logic [2:0] c_UC = 3'b000;
   localparam logic [2:0] c_SC = 3'b010;
   localparam logic [2:0] c_I  = 3'b100;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   ace_responder_if #(.ADDR_W(4), .DATA_W(32)) bus ();

   ace_responder #(
      .ADDR_W    (4),
      .DATA_W    (32),
      .READ_LAT  (c_RD_LAT),
      .WRITE_LAT (c_WR_LAT),
      .INV_LAT   (c_INV_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, hold it until ace_ready, drop it in that cycle.
   task automatic run_txn(input string tag, input int kind, input logic [3:0] a,
                          input logic [31:0] d, input logic ps, input int lat,
                          input int exp_inval);
      int cyc;
      int inv_cnt;
      bus.addr        = a;
      bus.wdata       = d;
      bus.peer_shared = ps;
      bus.write_req   = (kind == 1);
      bus.invalid_req = (kind == 2);
      bus.read_req    = (kind == 0);
      tick();
      check({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
      inv_cnt = int'(bus.peer_inval);
      cyc = 0;
      while (!bus.ace_ready && cyc < c_BOUND) begin
         tick();
         cyc++;
         if (bus.peer_inval) inv_cnt++;
         if (!bus.ace_ready && cyc < lat)
            check({tag, "_busy_wait"}, 64'(bus.busy), 64'd1);
      end
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      bus.read_req    = 1'b0;
      bus.write_req   = 1'b0;
      bus.invalid_req = 1'b0;
      tick();
      check({tag, "_ready_one_cycle"}, 64'(bus.ace_ready), 64'd0);
      check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_peer_inval_cnt"}, 64'(inv_cnt), 64'(exp_inval));
   endtask

   initial begin
      int cyc;
      int rdy_cnt;
      n_tests         = 0;
      n_fail          = 0;
      reset           = 1'b1;
      bus.read_req    = 1'b0;
      bus.write_req   = 1'b0;
      bus.invalid_req = 1'b0;
      bus.addr        = '0;
      bus.wdata       = '0;
      bus.peer_shared = 1'b0;
      tick();
      tick();
      check("rst_ace_ready", 64'(bus.ace_ready), 64'd0);
      check("rst_peer_inval", 64'(bus.peer_inval), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      check("rst_state", 64'(bus.resp_state), 64'(c_I));
      reset = 1'b0;
      tick();

      // Preload and read back, exclusive grant
      run_txn("wr3", 1, 4'd3, 32'hDEAD_BEEF, 1'b0, c_WR_LAT, 0);
      check("wr3_state", 64'(bus.resp_state), 64'(c_I));
      run_txn("rd3", 0, 4'd3, 32'h0, 1'b0, c_RD_LAT, 0);
      check("rd3_data", 64'(bus.rdata), 64'h0000_0000_DEAD_BEEF);
      check("rd3_state", 64'(bus.resp_state), 64'(c_UC));

      // Shared grant
      run_txn("wr5", 1, 4'd5, 32'h1234_5678, 1'b0, c_WR_LAT, 0);
      check("wr5_state", 64'(bus.resp_state), 64'(c_I));
      check("wr5_rdata_hold", 64'(bus.rdata), 64'h0000_0000_DEAD_BEEF);
      run_txn("rd5", 0, 4'd5, 32'h0, 1'b1, c_RD_LAT, 0);
      check("rd5_data", 64'(bus.rdata), 64'h0000_0000_1234_5678);
      check("rd5_state", 64'(bus.resp_state), 64'(c_SC));

      // Invalidate: single peer pulse, rdata untouched
      run_txn("inv", 2, 4'd1, 32'h0, 1'b1, c_INV_LAT, 1);
      check("inv_state", 64'(bus.resp_state), 64'(c_UC));
      check("inv_rdata", 64'(bus.rdata), 64'h0000_0000_1234_5678);

      // All three requests together: write wins, held read follows at edge WRITE_LAT+2
      bus.addr        = 4'd9;
      bus.wdata       = 32'hA5A5_0001;
      bus.peer_shared = 1'b0;
      bus.write_req   = 1'b1;
      bus.invalid_req = 1'b1;
      bus.read_req    = 1'b1;
      tick();
      check("pri_peer_inval", 64'(bus.peer_inval), 64'd0);
      cyc = 0;
      while (!bus.ace_ready && cyc < c_BOUND) begin
         tick();
         cyc++;
      end
      check("pri_wr_latency", 64'(cyc), 64'(c_WR_LAT));
      check("pri_wr_state", 64'(bus.resp_state), 64'(c_I));
      bus.write_req   = 1'b0;
      bus.invalid_req = 1'b0;
      tick();
      check("pri_idle_busy", 64'(bus.busy), 64'd0);
      tick();
      check("pri_rd_accept", 64'(bus.busy), 64'd1);
      cyc = 0;
      while (!bus.ace_ready && cyc < c_BOUND) begin
         tick();
         cyc++;
      end
      check("pri_rd_latency", 64'(cyc), 64'(c_RD_LAT));
      check("pri_rd_data", 64'(bus.rdata), 64'h0000_0000_A5A5_0001);
      check("pri_rd_state", 64'(bus.resp_state), 64'(c_UC));
      bus.read_req = 1'b0;
      tick();
      tick();

      // Requests toggled while busy produce no extra responses
      bus.addr     = 4'd3;
      bus.read_req = 1'b1;
      tick();
      rdy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ace_ready) begin
            rdy_cnt++;
            bus.read_req    = 1'b0;
            bus.write_req   = 1'b0;
            bus.invalid_req = 1'b0;
         end else if (i < 3) begin
            bus.write_req   = i[0];
            bus.invalid_req = ~i[0];
         end
      end
      check("tog_ready_cnt", 64'(rdy_cnt), 64'd1);
      check("tog_rdata", 64'(bus.rdata), 64'h0000_0000_DEAD_BEEF);
      check("tog_idle", 64'(bus.busy), 64'd0);

      // Reset on the commit edge of a write drops it
      run_txn("wr7", 1, 4'd7, 32'h0000_7777, 1'b0, c_WR_LAT, 0);
      bus.addr      = 4'd7;
      bus.wdata     = 32'hBAD0_BAD0;
      bus.write_req = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("rstw_ace_ready", 64'(bus.ace_ready), 64'd0);
      check("rstw_busy", 64'(bus.busy), 64'd0);
      check("rstw_state", 64'(bus.resp_state), 64'(c_I));
      check("rstw_rdata", 64'(bus.rdata), 64'd0);
      reset         = 1'b0;
      bus.write_req = 1'b0;
      rdy_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.ace_ready) rdy_cnt++;
      end
      check("rstw_no_ready", 64'(rdy_cnt), 64'd0);
      run_txn("rd7", 0, 4'd7, 32'h0, 1'b0, c_RD_LAT, 0);
      check("rd7_data", 64'(bus.rdata), 64'h0000_0000_0000_7777);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
